// File: rtl/sorted_word_serializer_pkg.sv
// ---------------------------------------------------------------------------
// sort_pkg
// Shared definitions for the packed sorted-word interface that runs between
// the 4-element sorting network and its consumers.
//   SORT_W, SORT_N : default element width and element count per word
//   elem_t         : one element
//   word_t         : packed word, element 0 in the LSBs
//   ser_state_e    : serializer FSM states
// ---------------------------------------------------------------------------
package sort_pkg;

  parameter int SORT_W = 4;
  parameter int SORT_N = 4;

  typedef logic [SORT_W-1:0] elem_t;
  typedef elem_t [SORT_N-1:0] word_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/sorted_word_serializer_if.sv
// ---------------------------------------------------------------------------
// sorted_word_serializer_if
// Groups both handshakes of the serializer.
//   Input side  : in_valid, in_ready, in_data (N*W packed), in_desc
//   Output side : out_valid, out_ready, out_data (W), out_last, out_unsorted
//   out_count   : distinct-element count, only when
//                 SORTED_WORD_SERIALIZER_DEDUP_EN is defined
// Modports:
//   slave  : the serializer itself
//   master : whoever feeds words in and drains elements out
// ---------------------------------------------------------------------------
interface sorted_word_serializer_if #(
  parameter int W = sort_pkg::SORT_W,
  parameter int N = sort_pkg::SORT_N
);

  localparam int CW = $clog2(N + 1);

  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_data;
  logic           in_desc;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic           out_unsorted;
`ifdef SORTED_WORD_SERIALIZER_DEDUP_EN
  logic [CW-1:0]  out_count;
`endif

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_data,
    input  in_desc,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_last,
`ifdef SORTED_WORD_SERIALIZER_DEDUP_EN
    output out_count,
`endif
    output out_unsorted
  );

  modport master (
    output in_valid,
    input  in_ready,
    output in_data,
    output in_desc,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_last,
`ifdef SORTED_WORD_SERIALIZER_DEDUP_EN
    input  out_count,
`endif
    input  out_unsorted
  );

endinterface

// File: rtl/sorted_word_serializer_sort_checker.sv
// ---------------------------------------------------------------------------
// sort_checker
// Purely combinational check that a packed word is non-decreasing from
// element 0 upward. Equal neighbours count as sorted.
//   data     : N*W packed word, element k at bits [k*W +: W]
//   unsorted : 1 when some element k+1 is smaller than element k
// ---------------------------------------------------------------------------
module sort_checker #(
  parameter int W = sort_pkg::SORT_W,
  parameter int N = sort_pkg::SORT_N
) (
  input  logic [N*W-1:0] data,
  output logic           unsorted
);

  always_comb begin
    unsorted = 1'b0;
    for (int k = 1; k < N; k++) begin
      if (data[k*W +: W] < data[(k-1)*W +: W]) begin
        unsorted = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sorted_word_serializer.sv
// ---------------------------------------------------------------------------
// sorted_word_serializer
// Accepts one packed word of N sorted W-bit elements and streams the
// elements out one per cycle, ascending or descending, with a last flag and
// a sortedness flag held for the whole word.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : sorted_word_serializer_if.slave (both valid/ready handshakes)
// Optional feature macro: SORTED_WORD_SERIALIZER_DEDUP_EN
//   When defined, elements equal to the previously emitted element of the
//   same word are skipped, out_last marks the last distinct element and
//   out_count reports the number of distinct elements.
// ---------------------------------------------------------------------------
module sorted_word_serializer
  import sort_pkg::*;
#(
  parameter int W = SORT_W,
  parameter int N = SORT_N
) (
  input logic                    clk,
  input logic                    rst_n,
  sorted_word_serializer_if.slave bus
);

  localparam int IW = $clog2(N);
`ifdef SORTED_WORD_SERIALIZER_DEDUP_EN
  localparam int CW = $clog2(N + 1);
`endif

  ser_state_e     state;
  ser_state_e     state_next;

  logic [N*W-1:0] word_q;
  logic [IW-1:0]  idx_q;
  logic [IW-1:0]  idx_step;
  logic           desc_q;
  logic           unsorted_q;
  logic           unsorted_in;
  logic [N-1:0]   keep_q;
  logic [N-1:0]   keep_in;
  logic           has_next;
  logic           in_ready_c;
  logic           accept;
`ifdef SORTED_WORD_SERIALIZER_DEDUP_EN
  logic [CW-1:0]  count_q;
  logic [CW-1:0]  count_in;
`endif

  sort_checker #(
    .W(W),
    .N(N)
  ) u_sort_checker (
    .data    (bus.in_data),
    .unsorted(unsorted_in)
  );

  // Which element positions of the incoming word will produce an output
  // cycle. The first element in emission order is always kept; with dedup a
  // later element is kept only when it differs from its predecessor in
  // emission order, which is exactly "differs from the last emitted value".
`ifdef SORTED_WORD_SERIALIZER_DEDUP_EN
  always_comb begin
    keep_in  = '0;
    count_in = '0;
    if (bus.in_desc) begin
      keep_in[N-1] = 1'b1;
      for (int k = 0; k < N - 1; k++) begin
        keep_in[k] = (bus.in_data[k*W +: W] != bus.in_data[(k+1)*W +: W]);
      end
    end else begin
      keep_in[0] = 1'b1;
      for (int k = 1; k < N; k++) begin
        keep_in[k] = (bus.in_data[k*W +: W] != bus.in_data[(k-1)*W +: W]);
      end
    end
    for (int k = 0; k < N; k++) begin
      count_in = count_in + CW'(keep_in[k]);
    end
  end
`else
  assign keep_in = '1;
`endif

  // Nearest kept position beyond the current index in the emission
  // direction. No such position means the current element is the last one,
  // so the index can never run past either end of the word.
  always_comb begin
    idx_step = idx_q;
    has_next = 1'b0;
    if (!desc_q) begin
      for (int k = 0; k < N; k++) begin
        if (!has_next && keep_q[k] && (k > int'(idx_q))) begin
          idx_step = IW'(k);
          has_next = 1'b1;
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (!has_next && keep_q[k] && (k < int'(idx_q))) begin
          idx_step = IW'(k);
          has_next = 1'b1;
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and input-side ready. A new word may be taken on the same
  // cycle the final element is handed off, which keeps back-to-back words
  // free of bubbles at the cost of a combinational out_ready -> in_ready path.
  always_comb begin
    state_next = state;
    in_ready_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (bus.out_ready && !has_next) begin
          in_ready_c = 1'b1;
          state_next = bus.in_valid ? EMIT : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign accept = bus.in_valid & in_ready_c;

  // Word buffer, direction, sortedness and emission index. A newly accepted
  // word always wins over stepping, since acceptance in EMIT only happens
  // on the final element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q     <= '0;
      idx_q      <= '0;
      desc_q     <= 1'b0;
      unsorted_q <= 1'b0;
      keep_q     <= '0;
`ifdef SORTED_WORD_SERIALIZER_DEDUP_EN
      count_q    <= '0;
`endif
    end else if (accept) begin
      word_q     <= bus.in_data;
      idx_q      <= bus.in_desc ? IW'(N - 1) : '0;
      desc_q     <= bus.in_desc;
      unsorted_q <= unsorted_in;
      keep_q     <= keep_in;
`ifdef SORTED_WORD_SERIALIZER_DEDUP_EN
      count_q    <= count_in;
`endif
    end else if ((state == EMIT) && bus.out_ready && has_next) begin
      idx_q <= idx_step;
    end
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.out_valid    = (state == EMIT);
  assign bus.out_data     = (state == EMIT) ? word_q[idx_q*W +: W] : '0;
  assign bus.out_last     = (state == EMIT) && !has_next;
  assign bus.out_unsorted = unsorted_q;
`ifdef SORTED_WORD_SERIALIZER_DEDUP_EN
  assign bus.out_count    = count_q;
`endif

endmodule

// File: tb/tb_sorted_word_serializer.sv
// ---------------------------------------------------------------------------
// tb_sorted_word_serializer
// Directed bench for sorted_word_serializer: a table of whole words with
// their expected emission order, plus hand-written sequences for stall,
// back-to-back, mid-word reset and equal-element words. Works with and
// without SORTED_WORD_SERIALIZER_DEDUP_EN.
// ---------------------------------------------------------------------------
module tb_sorted_word_serializer;
  import sort_pkg::*;

  logic clk;
  logic rst_n;

  int vectors;
  int miscompares;

  sorted_word_serializer_if #(.W(SORT_W), .N(SORT_N)) bus ();

  sorted_word_serializer #(
    .W(SORT_W),
    .N(SORT_N)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One word of the table: exp holds the expected emission order, first
  // emitted element in the low nibble.
  typedef struct {
    string name;
    word_t data;
    logic  desc;
    logic [15:0] exp;
    logic  unsorted;
  } vec_t;

  vec_t table_v[5];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present one word for a single cycle from IDLE; it is accepted at the
  // following rising edge.
  task automatic applyStimulus(input logic [15:0] data, input logic desc);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_desc  = desc;
    checkOutput("accept_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Walk n emitted elements with out_ready high, checking data, last,
  // unsorted and that the input side only opens on the last element.
  task automatic streamWord(input string name, input logic [15:0] exp,
                            input int n, input logic exp_unsorted,
                            input logic expect_idle);
    for (int e = 0; e < n; e++) begin
      @(negedge clk);
      checkOutput({name, "_valid"}, 32'(bus.out_valid), 32'd1);
      checkOutput({name, "_data"}, 32'(bus.out_data), 32'(exp[e*4 +: 4]));
      checkOutput({name, "_last"}, 32'(bus.out_last), 32'(e == n - 1));
      checkOutput({name, "_unsorted"}, 32'(bus.out_unsorted), 32'(exp_unsorted));
      checkOutput({name, "_in_ready"}, 32'(bus.in_ready), 32'(e == n - 1));
`ifdef SORTED_WORD_SERIALIZER_DEDUP_EN
      checkOutput({name, "_count"}, 32'(bus.out_count), 32'(n));
`endif
    end
    if (expect_idle) begin
      @(negedge clk);
      checkOutput({name, "_idle"}, 32'(bus.out_valid), 32'd0);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    table_v[0] = '{"asc_sorted",   16'hC852, 1'b0, 16'hC852, 1'b0};
    table_v[1] = '{"desc_sorted",  16'hC852, 1'b1, 16'h258C, 1'b0};
    table_v[2] = '{"asc_unsorted", 16'h3942, 1'b0, 16'h3942, 1'b1};
    table_v[3] = '{"desc_unsorted",16'h3942, 1'b1, 16'h2493, 1'b1};
    table_v[4] = '{"desc_fa71",    16'hFA71, 1'b1, 16'h17AF, 1'b0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_desc   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state.
    #12;
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(bus.out_data), 32'd0);
    checkOutput("rst_out_last", 32'(bus.out_last), 32'd0);
    checkOutput("rst_out_unsorted", 32'(bus.out_unsorted), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of whole words.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(table_v[i].data, table_v[i].desc);
      streamWord(table_v[i].name, table_v[i].exp, 4, table_v[i].unsorted, 1'b1);
    end

    // Stall: out_ready 1,0,0,1 over the first element cycles of 16'hFA71.
    applyStimulus(16'hFA71, 1'b0);
    @(negedge clk);
    checkOutput("stall_e0", 32'(bus.out_data), 32'h1);
    checkOutput("stall_in_ready0", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    checkOutput("stall_e1", 32'(bus.out_data), 32'h7);
    bus.out_ready = 1'b0;
    checkOutput("stall_in_ready1", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    checkOutput("stall_hold_data", 32'(bus.out_data), 32'h7);
    checkOutput("stall_hold_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("stall_hold_last", 32'(bus.out_last), 32'd0);
    @(negedge clk);
    checkOutput("stall_hold_data2", 32'(bus.out_data), 32'h7);
    checkOutput("stall_in_ready2", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("stall_e2", 32'(bus.out_data), 32'hA);
    checkOutput("stall_in_ready3", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    checkOutput("stall_e3", 32'(bus.out_data), 32'hF);
    checkOutput("stall_last", 32'(bus.out_last), 32'd1);
    checkOutput("stall_in_ready4", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    checkOutput("stall_idle", 32'(bus.out_valid), 32'd0);

    // Back-to-back: second word is held on the input while the first drains.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hC852;
    bus.in_desc  = 1'b0;
    @(posedge clk);
    #1;
    bus.in_data = 16'h7654;
    streamWord("b2b_first", 16'hC852, 4, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    streamWord("b2b_second", 16'h7654, 4, 1'b0, 1'b1);

    // Reset in the middle of a word.
    applyStimulus(16'hEDB1, 1'b0);
    @(negedge clk);
    checkOutput("midrst_e0", 32'(bus.out_data), 32'h1);
    @(negedge clk);
    checkOutput("midrst_e1", 32'(bus.out_data), 32'hB);
    @(negedge clk);
    checkOutput("midrst_e2", 32'(bus.out_data), 32'hD);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("midrst_data", 32'(bus.out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midrst_release_valid", 32'(bus.out_valid), 32'd0);
    applyStimulus(16'hEDB1, 1'b0);
    streamWord("after_rst", 16'hEDB1, 4, 1'b0, 1'b1);

    // Words with repeated elements.
`ifdef SORTED_WORD_SERIALIZER_DEDUP_EN
    applyStimulus(16'h5522, 1'b0);
    streamWord("dedup_asc", 16'h0052, 2, 1'b0, 1'b1);
    applyStimulus(16'h5522, 1'b1);
    streamWord("dedup_desc", 16'h0025, 2, 1'b0, 1'b1);
    applyStimulus(16'h7777, 1'b0);
    streamWord("dedup_same", 16'h0007, 1, 1'b0, 1'b1);
    applyStimulus(16'h2552, 1'b0);
    streamWord("dedup_unsorted", 16'h0252, 3, 1'b1, 1'b1);
`else
    applyStimulus(16'h5522, 1'b0);
    streamWord("equal_asc", 16'h5522, 4, 1'b0, 1'b1);
    applyStimulus(16'h7777, 1'b1);
    streamWord("equal_same", 16'h7777, 4, 1'b0, 1'b1);
    applyStimulus(16'h2552, 1'b0);
    streamWord("equal_unsorted", 16'h2552, 4, 1'b1, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
